// File: rtl/nf_prog_loader.sv
// UART program loader: receives an 8N1 load frame, writes little-endian words to
// instruction memory from word 0 and holds the CPU in reset while a frame is in flight.
module nf_prog_loader #(
  parameter int unsigned CLK_PER_BIT = 434,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADDR_W      = 6,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rx,
  output logic              cpu_resetn,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              done,
  output logic              err
);

  localparam int unsigned BCNT_W = 16;
  localparam int unsigned IDX_W  = ADDR_W + 1;
  localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(CLK_PER_BIT - 1);
  localparam logic [BCNT_W-1:0] HALF_LAST = BCNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [15:0]       DEPTH_C   = 16'(DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {F_IDLE, F_HDR_LO, F_HDR_HI, F_DATA, F_FINISH} f_state_e;

  // rx synchroniser plus one extra stage for falling-edge detection
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_e         rx_state_q, rx_state_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              rx_valid_c, rx_ferr_c;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_state_q <= RX_IDLE;
      bcnt_q     <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      bcnt_q     <= bcnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
    end
  end

  // Byte receiver: start re-checked at half bit, then mid-bit sampling LSB first
  always_comb begin
    rx_state_d = rx_state_q;
    bcnt_d     = bcnt_q + BCNT_W'(1);
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    rx_valid_c = 1'b0;
    rx_ferr_c  = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        bcnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (bcnt_q == HALF_LAST) begin
          bcnt_d     = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bcnt_q == BIT_LAST) begin
          bcnt_d    = '0;
          shreg_d   = {rx_sync_q, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (bcnt_q == BIT_LAST) begin
          bcnt_d     = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) rx_valid_c = 1'b1;
          else           rx_ferr_c  = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  f_state_e          f_state_q, f_state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]  widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [31:0]       word_q, word_d;
  logic              cpu_resetn_q, cpu_resetn_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      f_state_q    <= F_IDLE;
      cnt_q        <= '0;
      widx_q       <= '0;
      bidx_q       <= '0;
      word_q       <= '0;
      cpu_resetn_q <= 1'b1;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      f_state_q    <= f_state_d;
      cnt_q        <= cnt_d;
      widx_q       <= widx_d;
      bidx_q       <= bidx_d;
      word_q       <= word_d;
      cpu_resetn_q <= cpu_resetn_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Frame parser; done/cpu release are registered so they coincide with the FINISH cycle
  always_comb begin
    f_state_d    = f_state_q;
    cnt_d        = cnt_q;
    widx_d       = widx_q;
    bidx_d       = bidx_q;
    word_d       = word_q;
    cpu_resetn_d = cpu_resetn_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    done_d       = 1'b0;
    err_d        = err_q;
    unique case (f_state_q)
      F_IDLE: begin
        if (rx_valid_c && shreg_q == SYNC_BYTE) begin
          f_state_d    = F_HDR_LO;
          err_d        = 1'b0;
          cpu_resetn_d = 1'b0;
        end
      end
      F_HDR_LO: begin
        if (rx_valid_c) begin
          cnt_d[7:0] = shreg_q;
          f_state_d  = F_HDR_HI;
        end
      end
      F_HDR_HI: begin
        if (rx_valid_c) begin
          cnt_d[15:8] = shreg_q;
          if ({shreg_q, cnt_q[7:0]} == 16'd0) begin
            f_state_d    = F_FINISH;
            done_d       = 1'b1;
            cpu_resetn_d = 1'b1;
          end else if ({shreg_q, cnt_q[7:0]} > DEPTH_C) begin
            f_state_d = F_IDLE;
            err_d     = 1'b1;
          end else begin
            f_state_d = F_DATA;
            widx_d    = '0;
            bidx_d    = '0;
          end
        end
      end
      F_DATA: begin
        if (rx_valid_c) begin
          word_d = {shreg_q, word_q[31:8]};
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = widx_q[ADDR_W-1:0];
            wdata_d = {shreg_q, word_q[31:8]};
            widx_d  = widx_q + IDX_W'(1);
            if (16'(widx_q + IDX_W'(1)) == cnt_q) begin
              f_state_d    = F_FINISH;
              done_d       = 1'b1;
              cpu_resetn_d = 1'b1;
            end
          end
        end
      end
      F_FINISH: f_state_d = F_IDLE;
      default:  f_state_d = F_IDLE;
    endcase
    if (rx_ferr_c) begin
      err_d = 1'b1;
      if (f_state_q != F_IDLE) f_state_d = F_IDLE;
    end
  end

  assign cpu_resetn = cpu_resetn_q;
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_nf_prog_loader.sv
// Bench for nf_prog_loader: UART byte driver, frame-level reference model and write scoreboard.
module tb_nf_prog_loader;

  localparam int unsigned CPB    = 16;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              rx = 1'b1;
  logic              cpu_resetn, we, done, err;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  nf_prog_loader #(
    .CLK_PER_BIT(CPB),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx        (rx),
    .cpu_resetn(cpu_resetn),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observed writes and done pulses
  logic [37:0] obs_wr[$];
  logic [37:0] exp_wr[$];
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int we_cyc = -1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (we) begin
      obs_wr.push_back({waddr, wdata});
      we_cyc = cyc;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // Model state persisting across frames
  logic m_err = 1'b0;
  logic m_cpu = 1'b1;
  int   exp_done = 0;

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    if (!stop) repeat (2 * CPB) @(posedge clk);
    repeat ($urandom_range(0, 5)) @(posedge clk);
  endtask

  // pkt[g] is the sync byte; pkt[bad] (if bad>=0) is sent with a stop bit of 0 and ends the packet
  task automatic run_frame(input bq_t pkt, input int g, input int bad, input int glitch_after);
    int n, avail, cnt;
    obs_wr.delete();
    exp_wr.delete();
    done_cnt = 0;
    done_cyc = -1;
    we_cyc   = -1;
    exp_done = 0;

    n = (bad >= 0) ? bad : pkt.size();
    m_err = 1'b0;
    m_cpu = 1'b0;
    if (n >= g + 3) begin
      cnt = int'({pkt[g+2], pkt[g+1]});
      if (cnt == 0) begin
        exp_done = 1;
        m_cpu    = 1'b1;
      end else if (cnt > int'(DEPTH)) begin
        m_err = 1'b1;
      end else begin
        avail = (n - g - 3) / 4;
        if (avail > cnt) avail = cnt;
        for (int k = 0; k < avail; k++) begin
          exp_wr.push_back({6'(k), pkt[g+3+4*k+3], pkt[g+3+4*k+2], pkt[g+3+4*k+1], pkt[g+3+4*k]});
        end
        if (avail == cnt) begin
          exp_done = 1;
          m_cpu    = 1'b1;
        end
      end
    end
    if (bad >= 0) m_err = 1'b1;

    for (int i = 0; i < pkt.size(); i++) begin
      send_byte(pkt[i], (i != bad));
      if (i == g) begin
        repeat (2) @(posedge clk);
        #1;
        chk("cpu_held_after_sync", 64'(cpu_resetn), 64'(0));
        chk("err_clr_on_sync", 64'(err), 64'(0));
      end
      if (i == glitch_after) begin
        rx = 1'b0;
        repeat (8) @(posedge clk);
        rx = 1'b1;
        repeat (12 * CPB) @(posedge clk);
      end
      if (i == bad) break;
    end

    repeat (3 * CPB) @(posedge clk);
    #1;
    chk("n_writes", 64'(obs_wr.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++) begin
      if (i < obs_wr.size()) chk("write", 64'(obs_wr[i]), 64'(exp_wr[i]));
    end
    chk("done_count", 64'(done_cnt), 64'(exp_done));
    chk("err", 64'(err), 64'(m_err));
    chk("cpu_resetn", 64'(cpu_resetn), 64'(m_cpu));
    if (exp_done != 0 && exp_wr.size() > 0) chk("done_with_last_we", 64'(done_cyc), 64'(we_cyc));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cpu_resetn"}, 64'(cpu_resetn), 64'(1));
    chk({tag, "_we"}, 64'(we), 64'(0));
    chk({tag, "_waddr"}, 64'(waddr), 64'(0));
    chk({tag, "_wdata"}, 64'(wdata), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
  endtask

  initial begin
    bq_t pkt;
    int g, bad, cnt, mode;
    logic [7:0] v;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    resetn = 1'b1;
    m_err = 1'b0;
    m_cpu = 1'b1;
    repeat (5) @(posedge clk);

    // Two-word load
    pkt = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_frame(pkt, 0, -1, -1);
    // Empty frame
    pkt = '{8'hA5, 8'h00, 8'h00};
    run_frame(pkt, 0, -1, -1);
    // Count one past DEPTH, then a good single-word frame
    pkt = '{8'hA5, 8'h41, 8'h00};
    run_frame(pkt, 0, -1, -1);
    pkt = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(pkt, 0, -1, -1);
    // Framing error mid-DATA, then a good frame
    pkt = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_frame(pkt, 0, 8, -1);
    pkt = '{8'h3C, 8'hA5, 8'h01, 8'h00, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    run_frame(pkt, 1, -1, -1);
    // Start-bit glitch between bytes must not be taken as a byte
    pkt = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(pkt, 0, -1, 0);

    // Reset after two data bytes abandons the frame
    obs_wr.delete();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h9A, 1'b1);
    send_byte(8'hBC, 1'b1);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check_reset_values("midframe_reset");
    resetn = 1'b1;
    m_err = 1'b0;
    m_cpu = 1'b1;
    repeat (5) @(posedge clk);
    pkt = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
    run_frame(pkt, 0, -1, -1);

    // Randomized frames: garbage prefix, varied counts, occasional framing error
    for (int it = 0; it < 8; it++) begin
      pkt.delete();
      g = $urandom_range(0, 2);
      for (int j = 0; j < g; j++) begin
        v = 8'($urandom_range(0, 255));
        if (v == 8'hA5) v = 8'h5A;
        pkt.push_back(v);
      end
      mode = $urandom_range(0, 9);
      if (mode == 0)      cnt = 0;
      else if (mode == 1) cnt = $urandom_range(65, 300);
      else                cnt = $urandom_range(1, 4);
      pkt.push_back(8'hA5);
      pkt.push_back(8'(cnt));
      pkt.push_back(8'(cnt >> 8));
      if (cnt <= int'(DEPTH)) begin
        for (int j = 0; j < 4 * cnt; j++) pkt.push_back(8'($urandom_range(0, 255)));
      end
      bad = -1;
      if ($urandom_range(0, 3) == 0) bad = $urandom_range(g + 1, pkt.size() - 1);
      run_frame(pkt, g, bad, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
